ir_fetch_unit: RTL and testbench
================================

Name: ir_fetch_unit

Overview:
- Instruction-fetch and instruction-register stage of the accumulator processor; sits directly upstream of the sign extender.
- Issues 16-bit instruction reads to memory over a req/ack handshake and prefetches into a small buffer.
- Loads the instruction register when control asserts IRWrite.
- Presents registered IR fields (opcode, 11-bit immediate, 13-bit branch offset, msb select) that feed the sign extender and control unit.
- A branch/jump redirect flushes all fetched-but-unused instructions.

Parameters:
- DEPTH, 2: prefetch buffer entries (power of two, >=1).
- RESET_PC, 16'h0000: first fetch address after reset.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_n  in  1  synchronous active-low reset.
- redirect  in  1  taken branch/jump; load fetch PC from pc_in, flush.
- pc_in  in  16  redirect target address.
- IRWrite  in  1  control request to load next instruction into IR.
- mem_req  out  1  memory read request (registered).
- mem_addr  out  16  read address (registered).
- mem_ack  in  1  memory read complete; mem_rdata valid this cycle.
- mem_rdata  in  16  instruction word.
- ir_valid  out  1  IR holds a valid instruction.
- IR_opcode  out  5  IR[15:11].
- IR_immediate  out  11  IR[10:0].
- IR_branch  out  13  IR[12:0].
- IR_msb  out  1  IR[15]; 1 = branch format, selects IR_branch in the sign extender.
- pc_out  out  16  address of the instruction currently in IR.

Behaviour:
- Reset (RST_n low at a rising edge):
  - mem_req=0, mem_addr=RESET_PC, ir_valid=0, IR=16'h0000 (all fields 0), pc_out=0.
  - Buffer emptied; fetch PC=RESET_PC.
  - Reset mid-transaction abandons any outstanding request; a mem_ack during reset is ignored.
- Memory handshake:
  - While mem_req=1, mem_addr is held stable until a cycle with mem_ack=1.
  - mem_rdata is captured on the ack edge.
  - At most one request is outstanding.
  - mem_ack while mem_req=0 is ignored.
- Fetch control FSM:
  - IDLE: mem_req=0. Go to REQ when buffer count (after this cycle's push/pop) < DEPTH and redirect=0.
  - REQ: mem_req=1.
    - On ack: push {addr, data} and increment fetch PC (16-bit wrap, 0xFFFF -> 0x0000).
    - Stay in REQ with the new address if space remains, else go to IDLE.
  - First request is asserted on the cycle after reset deasserts.
- IR load:
  - When IRWrite=1 and the buffer is non-empty: IR <= head data, pc_out <= head addr, ir_valid <= 1, pop.
  - IRWrite=1 with an empty buffer: ir_valid <= 0, IR unchanged.
  - IRWrite=0: IR and ir_valid hold.
  - A word acked this cycle into an empty buffer is not bypassed; it becomes loadable the next cycle. Ack-to-IR latency is 1 cycle minimum.
- Redirect (highest priority, wins over IRWrite and mem_ack):
  - Buffer cleared and ir_valid <= 0.
  - Any data acked in the same cycle is discarded.
  - mem_req <= 0 for that edge; fetch PC <= pc_in.
  - Request to pc_in is issued on the following cycle.
- Simultaneous push and pop: count unchanged.
- Full buffer with pop: a new request may issue the same cycle.
- IR fields are pure slices of the IR register, so all outputs are registered.

Decomposition:
- Shared header fetch_defs.vh:
  - field positions: OPC_HI=15, OPC_LO=11, IMM_W=11, BR_W=13, MSB_BIT=15
  - RESET_PC default
  - FSM state encodings IDLE=0, REQ=1
- One sub-module fetch_fifo: parameterised DEPTH, 32-bit entries {addr, data}, push/pop/flush, count, empty/full.

Test Plan:
1. Reset, then zero-wait memory returning 16'h1234 @0 and 16'h9FFC @1, IRWrite pulses -> first load: IR_opcode=5'b00010, IR_immediate=11'h234, IR_msb=0, pc_out=0; next: IR_msb=1, IR_branch=13'h1FFC (sign extender yields 16'hFFFC), pc_out=1.
2. IRWrite held 0 with DEPTH=2 -> exactly 2 acks accepted, then mem_req=0 with mem_addr=2; one IRWrite pulse -> mem_req reasserts at addr 2.
3. Ack delayed 3 cycles -> mem_req=1 and mem_addr constant for all 3 cycles; data captured only on the ack edge.
4. redirect=1, pc_in=16'h0040 in the same cycle as mem_ack (data 16'hBEEF) and IRWrite -> 16'hBEEF never reaches IR, ir_valid=0, mem_req=0 for one cycle, then request at 16'h0040.
5. Redirect to 16'hFFFF -> after that ack, next mem_addr=16'h0000; pc_out of the second instruction =16'h0000.
6. RST_n low for one edge during an outstanding request with ack asserted -> next cycle all outputs equal reset values; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/ir_fetch_unit_pkg.sv
// ir_fetch_unit_pkg: IR field positions, reset PC, fetch FSM states and buffer entry type
package ir_fetch_unit_pkg;
  localparam int OPC_HI = 15;
  localparam int OPC_LO = 11;
  localparam int IMM_W = 11;
  localparam int BR_W = 13;
  localparam int MSB_BIT = 15;
  localparam logic [15:0] RESET_PC_DEF = 16'h0000;
  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } fetch_state_e;
  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
  } fetch_entry_t;
endpackage

// File: rtl/ir_fetch_unit_fifo.sv
// ir_fetch_unit_fifo: prefetch buffer of {addr, data} entries with push/pop/flush
module ir_fetch_unit_fifo
  import ir_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic         CLK,
  input  logic         RST_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  fetch_entry_t wdata_i,
  output fetch_entry_t rdata_o,
  output logic [CW-1:0] count_o,
  output logic         empty_o,
  output logic         full_o
);
  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] count_q;
  logic          wr_en, rd_en;
  assign empty_o = count_q == '0;
  assign full_o  = count_q == CW'(DEPTH);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_q];
  // a pop frees the slot, so a push into a full buffer is allowed alongside it
  assign wr_en = push_i & (~full_o | pop_i);
  assign rd_en = pop_i & ~empty_o;
  always_ff @(posedge CLK) begin
    if (!RST_n || flush_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (wr_en) wr_q <= DEPTH == 1 ? '0 : wr_q + 1'b1;
      if (rd_en) rd_q <= DEPTH == 1 ? '0 : rd_q + 1'b1;
      count_q <= count_q + CW'(wr_en) - CW'(rd_en);
    end
  end
  always_ff @(posedge CLK) begin
    if (wr_en) mem_q[wr_q] <= wdata_i;
  end
endmodule

// File: rtl/ir_fetch_unit.sv
// ir_fetch_unit: instruction prefetch over req/ack memory plus registered instruction register
module ir_fetch_unit
  import ir_fetch_unit_pkg::*;
#(
  parameter int          DEPTH    = 2,
  parameter logic [15:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        CLK,
  input  logic        RST_n,
  input  logic        redirect,
  input  logic [15:0] pc_in,
  input  logic        IRWrite,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic        ir_valid,
  output logic [4:0]  IR_opcode,
  output logic [10:0] IR_immediate,
  output logic [12:0] IR_branch,
  output logic        IR_msb,
  output logic [15:0] pc_out
);
  localparam int CW = $clog2(DEPTH + 1);
  fetch_state_e  state_q;
  logic          req_q, ir_valid_q;
  logic [15:0]   pc_q, ir_q, pc_out_q;
  logic          push, pop, empty, full, space;
  logic [CW-1:0] count;
  logic [CW:0]   occ_d;
  fetch_entry_t  head;
  // redirect beats both a same-cycle ack and a same-cycle IR load
  assign push  = req_q & mem_ack & ~redirect;
  assign pop   = IRWrite & ~empty & ~redirect;
  assign occ_d = {1'b0, count} + (CW+1)'(push) - (CW+1)'(pop);
  assign space = occ_d < (CW+1)'(DEPTH);
  ir_fetch_unit_fifo #(.DEPTH(DEPTH)) u_fifo (
    .CLK     (CLK),
    .RST_n   (RST_n),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect),
    .wdata_i ({pc_q, mem_rdata}),
    .rdata_o (head),
    .count_o (count),
    .empty_o (empty),
    .full_o  (full)
  );
  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      pc_q    <= RESET_PC;
    end else if (redirect) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      pc_q    <= pc_in;
    end else if (state_q == REQ) begin
      if (mem_ack) begin
        pc_q    <= pc_q + 16'd1;
        state_q <= space ? REQ : IDLE;
        req_q   <= space;
      end
    end else if (~full | pop) begin
      state_q <= REQ;
      req_q   <= 1'b1;
    end
  end
  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      ir_q       <= '0;
      pc_out_q   <= '0;
      ir_valid_q <= 1'b0;
    end else if (redirect) begin
      ir_valid_q <= 1'b0;
    end else if (IRWrite) begin
      ir_valid_q <= ~empty;
      if (!empty) begin
        ir_q     <= head.data;
        pc_out_q <= head.addr;
      end
    end
  end
  assign mem_req      = req_q;
  assign mem_addr     = pc_q;
  assign ir_valid     = ir_valid_q;
  assign IR_opcode    = ir_q[OPC_HI:OPC_LO];
  assign IR_immediate = ir_q[IMM_W-1:0];
  assign IR_branch    = ir_q[BR_W-1:0];
  assign IR_msb       = ir_q[MSB_BIT];
  assign pc_out       = pc_out_q;
endmodule

// File: tb/tb_ir_fetch_unit.sv
// tb_ir_fetch_unit: scoreboard bench with a behavioural req/ack memory
module tb_ir_fetch_unit;
  logic        CLK = 1'b0;
  logic        RST_n, redirect, IRWrite, mem_ack, mem_req, ir_valid, IR_msb;
  logic [15:0] pc_in, mem_rdata, mem_addr, pc_out;
  logic [4:0]  IR_opcode;
  logic [10:0] IR_immediate;
  logic [12:0] IR_branch;
  int          errors = 0, checks = 0, ack_delay = 0, wait_cnt = 0, ack_count = 0;
  logic [15:0] ack_addr;
  logic [31:0] exp_q [$];

  ir_fetch_unit dut (
    .CLK(CLK), .RST_n(RST_n), .redirect(redirect), .pc_in(pc_in), .IRWrite(IRWrite),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .ir_valid(ir_valid), .IR_opcode(IR_opcode), .IR_immediate(IR_immediate),
    .IR_branch(IR_branch), .IR_msb(IR_msb), .pc_out(pc_out)
  );

  always #5 CLK = ~CLK;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return a == 16'h0000 ? 16'h1234 : a == 16'h0001 ? 16'h9FFC : (a ^ 16'h5A3C) + 16'h0101;
  endfunction

  // memory model: acks ack_delay cycles after a request, scoreboard records accepted words
  always @(posedge CLK) begin
    #2;
    if (mem_ack && RST_n && !redirect) begin
      exp_q.push_back({ack_addr, mem_rdata});
      ack_count++;
    end
    mem_ack = 1'b0;
    if (mem_req) begin
      if (wait_cnt >= ack_delay) begin
        mem_ack   = 1'b1;
        ack_addr  = mem_addr;
        mem_rdata = mem_word(mem_addr);
        wait_cnt  = 0;
      end else wait_cnt++;
    end else wait_cnt = 0;
  end

  task automatic do_reset();
    @(negedge CLK);
    RST_n = 1'b0; IRWrite = 1'b0; redirect = 1'b0;
    repeat (2) @(negedge CLK);
    exp_q.delete();
    ack_count = 0;
  endtask

  task automatic load_ir(input string nm, output logic [31:0] got);
    logic [31:0] e;
    logic        has;
    has = exp_q.size() > 0;
    e = has ? exp_q.pop_front() : 32'h0;
    IRWrite = 1'b1;
    @(negedge CLK);
    IRWrite = 1'b0;
    got = {pc_out, IR_opcode, IR_immediate};
    checks++;
    if (ir_valid !== has) begin errors++; $display("FAIL %s ir_valid: got %b expected %b", nm, ir_valid, has); end
    if (has) begin
      checks++;
      if (got !== e) begin errors++; $display("FAIL %s {pc,IR}: got %h expected %h", nm, got, e); end
      checks++;
      if ({IR_msb, IR_branch} !== {e[15], e[12:0]}) begin
        errors++; $display("FAIL %s msb/branch: got %b/%h expected %b/%h", nm, IR_msb, IR_branch, e[15], e[12:0]);
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({mem_req, mem_addr, ir_valid, IR_opcode, IR_immediate, IR_branch, IR_msb, pc_out} !== '0) begin
      errors++; $display("FAIL reset outputs: got req=%b addr=%h v=%b op=%h imm=%h br=%h msb=%b pc=%h expected all 0",
        mem_req, mem_addr, ir_valid, IR_opcode, IR_immediate, IR_branch, IR_msb, pc_out);
    end
  endtask

  task automatic test_fields();
    logic [31:0] g;
    do_reset();
    RST_n = 1'b1;
    @(negedge CLK);
    checks++;
    if ({mem_req, mem_addr} !== {1'b1, 16'h0000}) begin
      errors++; $display("FAIL first_req: got req=%b addr=%h expected req=1 addr=0000", mem_req, mem_addr);
    end
    repeat (3) @(negedge CLK);
    load_ir("load0", g);
    checks++;
    if ({IR_opcode, IR_immediate, IR_msb, pc_out} !== {5'b00010, 11'h234, 1'b0, 16'h0000}) begin
      errors++; $display("FAIL load0 fields: got op=%b imm=%h msb=%b pc=%h expected 00010 234 0 0000", IR_opcode, IR_immediate, IR_msb, pc_out);
    end
    load_ir("load1", g);
    checks++;
    if ({IR_msb, IR_branch, pc_out} !== {1'b1, 13'h1FFC, 16'h0001}) begin
      errors++; $display("FAIL load1 fields: got msb=%b br=%h pc=%h expected 1 1ffc 0001", IR_msb, IR_branch, pc_out);
    end
  endtask

  task automatic test_full_stall();
    logic [31:0] g;
    do_reset();
    RST_n = 1'b1;
    repeat (6) @(negedge CLK);
    checks++;
    if ({ack_count, mem_req, mem_addr} !== {32'd2, 1'b0, 16'h0002}) begin
      errors++; $display("FAIL full_stall: got acks=%0d req=%b addr=%h expected 2 0 0002", ack_count, mem_req, mem_addr);
    end
    load_ir("stall_load", g);
    checks++;
    if ({mem_req, mem_addr} !== {1'b1, 16'h0002}) begin
      errors++; $display("FAIL refetch: got req=%b addr=%h expected 1 0002", mem_req, mem_addr);
    end
  endtask

  task automatic test_slow_ack();
    logic [31:0] g;
    do_reset();
    ack_delay = 3;
    RST_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      IRWrite = (i == 0);
      checks++;
      if ({mem_req, mem_addr} !== {1'b1, 16'h0000}) begin
        errors++; $display("FAIL slow_hold[%0d]: got req=%b addr=%h expected 1 0000", i, mem_req, mem_addr);
      end
      if (i == 1) begin
        checks++;
        if (ir_valid !== 1'b0) begin errors++; $display("FAIL slow_empty_load: got ir_valid=%b expected 0", ir_valid); end
      end
    end
    @(negedge CLK);
    checks++;
    if (mem_addr !== 16'h0001) begin errors++; $display("FAIL slow_advance: got addr=%h expected 0001", mem_addr); end
    load_ir("slow_load", g);
    ack_delay = 0;
  endtask

  task automatic test_redirect();
    logic [31:0] g;
    do_reset();
    RST_n = 1'b1;
    repeat (3) @(negedge CLK);
    load_ir("pre_redirect", g);
    mem_rdata = 16'hBEEF;
    redirect = 1'b1; pc_in = 16'h0040; IRWrite = 1'b1;
    @(negedge CLK);
    redirect = 1'b0; IRWrite = 1'b0;
    exp_q.delete();
    checks++;
    if ({ir_valid, mem_req} !== 2'b00) begin
      errors++; $display("FAIL redirect_flush: got v=%b req=%b expected 0 0", ir_valid, mem_req);
    end
    checks++;
    if ({IR_opcode, IR_immediate} !== 16'h1234) begin
      errors++; $display("FAIL redirect_ir_hold: got %h expected 1234", {IR_opcode, IR_immediate});
    end
    @(negedge CLK);
    checks++;
    if ({mem_req, mem_addr} !== {1'b1, 16'h0040}) begin
      errors++; $display("FAIL redirect_req: got req=%b addr=%h expected 1 0040", mem_req, mem_addr);
    end
    @(negedge CLK);
    load_ir("target_load", g);
    checks++;
    if (pc_out !== 16'h0040) begin errors++; $display("FAIL target_pc: got %h expected 0040", pc_out); end
  endtask

  task automatic test_wrap();
    logic [31:0] g;
    redirect = 1'b1; pc_in = 16'hFFFF;
    @(negedge CLK);
    redirect = 1'b0;
    exp_q.delete();
    @(negedge CLK);
    checks++;
    if ({mem_req, mem_addr} !== {1'b1, 16'hFFFF}) begin
      errors++; $display("FAIL wrap_req: got req=%b addr=%h expected 1 ffff", mem_req, mem_addr);
    end
    @(negedge CLK);
    checks++;
    if (mem_addr !== 16'h0000) begin errors++; $display("FAIL wrap_addr: got %h expected 0000", mem_addr); end
    load_ir("wrap_load0", g);
    checks++;
    if (pc_out !== 16'hFFFF) begin errors++; $display("FAIL wrap_pc0: got %h expected ffff", pc_out); end
    load_ir("wrap_load1", g);
    checks++;
    if (pc_out !== 16'h0000) begin errors++; $display("FAIL wrap_pc1: got %h expected 0000", pc_out); end
  endtask

  task automatic test_reset_midflight();
    logic [31:0] g;
    do_reset();
    RST_n = 1'b1;
    repeat (3) @(negedge CLK);
    load_ir("pre_reset", g);
    checks++;
    if ({mem_req, mem_ack} !== 2'b11) begin
      errors++; $display("FAIL midflight_setup: got req=%b ack=%b expected 1 1", mem_req, mem_ack);
    end
    RST_n = 1'b0;
    @(negedge CLK);
    exp_q.delete();
    RST_n = 1'b1;
    checks++;
    if ({mem_req, mem_addr, ir_valid, IR_opcode, IR_immediate, IR_branch, IR_msb, pc_out} !== '0) begin
      errors++; $display("FAIL midflight_reset: got req=%b addr=%h v=%b op=%h imm=%h pc=%h expected all 0",
        mem_req, mem_addr, ir_valid, IR_opcode, IR_immediate, pc_out);
    end
    @(negedge CLK);
    checks++;
    if ({mem_req, mem_addr} !== {1'b1, 16'h0000}) begin
      errors++; $display("FAIL restart_req: got req=%b addr=%h expected 1 0000", mem_req, mem_addr);
    end
    @(negedge CLK);
    load_ir("restart_load", g);
  endtask

  initial begin
    RST_n = 1'b0; redirect = 1'b0; IRWrite = 1'b0; pc_in = '0; mem_ack = 1'b0; mem_rdata = '0;
    test_reset();
    test_fields();
    test_full_stall();
    test_slow_ack();
    test_redirect();
    test_wrap();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
